// File: rtl/hex_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hex_capture_pkg
// Brief    : Shared constants for hex_capture_bank: active-low gfedcba
//            7-segment glyphs and capture mode encodings.
// Revision : 1.0 - initial release
// ============================================================================
package hex_capture_pkg;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;  // lowercase b
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;  // lowercase d
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;

  // Capture behaviour once the bank is full
  localparam logic MODE_RING = 1'b0;
  localparam logic MODE_HALT = 1'b1;

endpackage : hex_capture_pkg
`default_nettype wire

// File: rtl/hex7seg.sv
`default_nettype none
// ============================================================================
// Module   : hex7seg
// Brief    : 4-bit nibble to active-low 7-segment hex glyph decoder.
// Revision : 1.0 - initial release
// ============================================================================
module hex7seg
  import hex_capture_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Pure lookup from nibble value to glyph
  always_comb begin
    seg = SEG_BLANK;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule : hex7seg
`default_nettype wire

// File: rtl/hex_capture_bank.sv
`default_nettype none
// ============================================================================
// Module   : hex_capture_bank
// Brief    : DEPTH-entry capture bank for a WIDTH-bit switch word with ring or
//            halt-when-full modes, synchronous clear, and two active-low hex
//            displays (selected stored entry and live input).
// Revision : 1.0 - initial release
// ============================================================================
module hex_capture_bank
  import hex_capture_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     resetnot,
  input  logic [WIDTH-1:0]         D,
  input  logic                     cap_en,
  input  logic                     clr,
  input  logic                     mode,
  input  logic [AW-1:0]            view_sel,
  output logic [7*(WIDTH/4)-1:0]   HEXA,
  output logic [7*(WIDTH/4)-1:0]   HEXB,
  output logic [AW-1:0]            wr_ptr,
  output logic [AW:0]              count,
  output logic                     full
);

  localparam int             NDIG       = WIDTH / 4;
  localparam logic [AW:0]    C_DEPTH    = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]  C_LAST_PTR = AW'(DEPTH - 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_count;
  logic             r_full;

  logic             w_accept;
  logic [AW:0]      w_count_nxt;
  logic             w_view_ok;
  logic [WIDTH-1:0] w_view_word;

  // A capture is refused only while halting on a full bank; clr always wins
  assign w_accept    = cap_en && !clr && !((mode == MODE_HALT) && r_full);
  assign w_count_nxt = (r_count == C_DEPTH) ? C_DEPTH : r_count + 1'b1;

  // Storage bank: cleared by reset or clr, written at the pointer on accept
  always_ff @(posedge clk or negedge resetnot) begin
    if (!resetnot) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_accept) begin
      r_mem[r_wr_ptr] <= D;
    end
  end

  // Pointer, occupancy and full flag advance together on an accepted capture
  always_ff @(posedge clk or negedge resetnot) begin
    if (!resetnot) begin
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else if (w_accept) begin
      r_wr_ptr <= (r_wr_ptr == C_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == C_DEPTH);
    end
  end

  // Out-of-range selections (DEPTH not a power of two) blank the display
  assign w_view_ok   = ({1'b0, view_sel} < C_DEPTH);
  assign w_view_word = w_view_ok ? r_mem[view_sel] : '0;

  generate
    for (genvar k = 0; k < NDIG; k++) begin : g_dig
      logic [6:0] w_seg_a;
      logic [6:0] w_seg_b;

      hex7seg u_seg_a (.nib(w_view_word[4*k +: 4]), .seg(w_seg_a));
      hex7seg u_seg_b (.nib(D[4*k +: 4]),           .seg(w_seg_b));

      assign HEXA[7*k +: 7] = w_view_ok ? w_seg_a : SEG_BLANK;
      assign HEXB[7*k +: 7] = w_seg_b;
    end
  endgenerate

  assign wr_ptr = r_wr_ptr;
  assign count  = r_count;
  assign full   = r_full;

endmodule : hex_capture_bank
`default_nettype wire

// File: tb/tb_hex_capture_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_capture_bank
// Brief    : Directed testbench for hex_capture_bank (DEPTH=4 and DEPTH=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hex_capture_bank;

  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100,
                         G3 = 7'b0110000, G4 = 7'b0011001, G5 = 7'b0010010,
                         G6 = 7'b0000010, G7 = 7'b1111000, G8 = 7'b0000000,
                         G9 = 7'b0010000, GA = 7'b0001000, GB = 7'b0000011,
                         GC = 7'b1000110, GD = 7'b0100001, GE = 7'b0000110,
                         GF = 7'b0001110;

  logic [6:0] glyph [16];

  logic        clk = 1'b0;
  logic        resetnot;

  // DEPTH=4 instance signals
  logic [7:0]  d;
  logic        cap_en, clr, mode;
  logic [1:0]  view_sel;
  logic [13:0] hexa, hexb;
  logic [1:0]  wr_ptr;
  logic [2:0]  count;
  logic        full;

  // DEPTH=3 instance signals
  logic [7:0]  d3;
  logic        cap3;
  logic [1:0]  view3;
  logic [13:0] hexa3, hexb3;
  logic [1:0]  wr_ptr3;
  logic [2:0]  count3;
  logic        full3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hex_capture_bank #(.WIDTH(8), .DEPTH(4)) u_dut (
    .clk(clk), .resetnot(resetnot), .D(d), .cap_en(cap_en), .clr(clr),
    .mode(mode), .view_sel(view_sel), .HEXA(hexa), .HEXB(hexb),
    .wr_ptr(wr_ptr), .count(count), .full(full)
  );

  hex_capture_bank #(.WIDTH(8), .DEPTH(3)) u_dut3 (
    .clk(clk), .resetnot(resetnot), .D(d3), .cap_en(cap3), .clr(1'b0),
    .mode(1'b0), .view_sel(view3), .HEXA(hexa3), .HEXB(hexb3),
    .wr_ptr(wr_ptr3), .count(count3), .full(full3)
  );

  // One capture on the DEPTH=4 instance; returns 1 ns after the edge
  task automatic cap(input logic [7:0] v);
    d = v; cap_en = 1'b1;
    @(posedge clk); #1;
    cap_en = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] vals [2];
    resetnot = 1'b0;
    #12;
    total++;
    if (count !== 3'd0 || wr_ptr !== 2'd0 || full !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: count=%0d wr_ptr=%0d full=%0b want 0/0/0", count, wr_ptr, full);
    end
    @(negedge clk); resetnot = 1'b1;
    @(posedge clk); #1;
    vals[0] = 8'h3C; vals[1] = 8'hD7;
    for (int i = 0; i < 2; i++) cap(vals[i]);
    total++;
    if (count !== 3'd2 || wr_ptr !== 2'd2) begin
      bad++;
      $display("FAIL pre_reset: count=%0d wr_ptr=%0d want 2/2", count, wr_ptr);
    end
    // Pulse reset between edges and check without waiting for a clock
    #2 resetnot = 1'b0;
    #1;
    total++;
    if (count !== 3'd0 || wr_ptr !== 2'd0 || full !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: count=%0d wr_ptr=%0d full=%0b want 0/0/0", count, wr_ptr, full);
    end
    for (int v = 0; v < 4; v++) begin
      view_sel = 2'(v); #1;
      total++;
      if (hexa !== {G0, G0}) begin
        bad++;
        $display("FAIL reset_hexa view%0d: got %h want %h", v, hexa, {G0, G0});
      end
    end
    #1 resetnot = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ring();
    logic [7:0] seq [5];
    logic [7:0] exp_mem [4];
    seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    exp_mem = '{8'h55, 8'h22, 8'h33, 8'h44};
    mode = 1'b0;
    for (int i = 0; i < 4; i++) cap(seq[i]);
    total++;
    if (count !== 3'd4 || full !== 1'b1 || wr_ptr !== 2'd0) begin
      bad++;
      $display("FAIL ring_fill: count=%0d full=%0b wr_ptr=%0d want 4/1/0", count, full, wr_ptr);
    end
    cap(seq[4]);
    total++;
    if (count !== 3'd4 || full !== 1'b1 || wr_ptr !== 2'd1) begin
      bad++;
      $display("FAIL ring_wrap: count=%0d full=%0b wr_ptr=%0d want 4/1/1", count, full, wr_ptr);
    end
    for (int v = 0; v < 4; v++) begin
      view_sel = 2'(v); #1;
      total++;
      if (hexa !== {glyph[exp_mem[v][7:4]], glyph[exp_mem[v][3:0]]}) begin
        bad++;
        $display("FAIL ring_mem view%0d: got %h want %h", v, hexa,
                 {glyph[exp_mem[v][7:4]], glyph[exp_mem[v][3:0]]});
      end
    end
    view_sel = 2'd0; #1;
    total++;
    if (hexa !== {G5, G5}) begin
      bad++;
      $display("FAIL ring_view0: got %h want %h", hexa, {G5, G5});
    end
  endtask

  task automatic test_halt();
    logic [7:0] seq [5];
    logic [7:0] exp_mem [4];
    seq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    exp_mem = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_clr();
    mode = 1'b1;
    for (int i = 0; i < 5; i++) cap(seq[i]);
    total++;
    if (count !== 3'd4 || full !== 1'b1 || wr_ptr !== 2'd0) begin
      bad++;
      $display("FAIL halt_state: count=%0d full=%0b wr_ptr=%0d want 4/1/0", count, full, wr_ptr);
    end
    for (int v = 0; v < 4; v++) begin
      view_sel = 2'(v); #1;
      total++;
      if (hexa !== {glyph[exp_mem[v][7:4]], glyph[exp_mem[v][3:0]]}) begin
        bad++;
        $display("FAIL halt_mem view%0d: got %h want %h", v, hexa,
                 {glyph[exp_mem[v][7:4]], glyph[exp_mem[v][3:0]]});
      end
    end
    mode = 1'b0;
    cap(8'h66);
    view_sel = 2'd0; #1;
    total++;
    if (hexa !== {G6, G6} || wr_ptr !== 2'd1 || count !== 3'd4 || full !== 1'b1) begin
      bad++;
      $display("FAIL halt_resume: hexa=%h wr_ptr=%0d count=%0d full=%0b want %h/1/4/1",
               hexa, wr_ptr, count, full, {G6, G6});
    end
    view_sel = 2'd1; #1;
    total++;
    if (hexa !== {G2, G2}) begin
      bad++;
      $display("FAIL halt_resume_slot1: got %h want %h", hexa, {G2, G2});
    end
  endtask

  task automatic test_clr_priority();
    d = 8'hAB; clr = 1'b1; cap_en = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    total++;
    if (count !== 3'd0 || wr_ptr !== 2'd0 || full !== 1'b0) begin
      bad++;
      $display("FAIL clr_state: count=%0d wr_ptr=%0d full=%0b want 0/0/0", count, wr_ptr, full);
    end
    for (int v = 0; v < 4; v++) begin
      view_sel = 2'(v); #1;
      total++;
      if (hexa !== {G0, G0}) begin
        bad++;
        $display("FAIL clr_mem view%0d: got %h want %h", v, hexa, {G0, G0});
      end
    end
    // cap_en still high: next edge captures AB into slot 0
    @(posedge clk); #1;
    cap_en = 1'b0;
    view_sel = 2'd0; #1;
    total++;
    if (hexa !== {GA, GB} || count !== 3'd1 || wr_ptr !== 2'd1) begin
      bad++;
      $display("FAIL clr_then_cap: hexa=%h count=%0d wr_ptr=%0d want %h/1/1",
               hexa, count, wr_ptr, {GA, GB});
    end
  endtask

  task automatic test_depth3();
    logic [1:0] exp_ptr [4];
    logic [2:0] exp_cnt [4];
    logic [7:0] vals [4];
    exp_ptr = '{2'd1, 2'd2, 2'd0, 2'd1};
    exp_cnt = '{3'd1, 3'd2, 3'd3, 3'd3};
    vals    = '{8'h12, 8'h34, 8'h56, 8'h9E};
    view3 = 2'd3; #1;
    total++;
    if (hexa3 !== 14'h3FFF) begin
      bad++;
      $display("FAIL d3_blank: got %h want %h", hexa3, 14'h3FFF);
    end
    for (int i = 0; i < 4; i++) begin
      d3 = vals[i]; cap3 = 1'b1;
      @(posedge clk); #1;
      cap3 = 1'b0;
      total++;
      if (wr_ptr3 !== exp_ptr[i] || count3 !== exp_cnt[i] || full3 !== (exp_cnt[i] == 3'd3)) begin
        bad++;
        $display("FAIL d3_step%0d: wr_ptr=%0d count=%0d full=%0b want %0d/%0d/%0b", i,
                 wr_ptr3, count3, full3, exp_ptr[i], exp_cnt[i], exp_cnt[i] == 3'd3);
      end
    end
    view3 = 2'd0; #1;
    total++;
    if (hexa3 !== {G9, GE}) begin
      bad++;
      $display("FAIL d3_overwrite: got %h want %h", hexa3, {G9, GE});
    end
    view3 = 2'd3; #1;
    total++;
    if (hexa3 !== 14'h3FFF) begin
      bad++;
      $display("FAIL d3_blank_full: got %h want %h", hexa3, 14'h3FFF);
    end
  endtask

  task automatic test_live();
    d = 8'h0F; #1;
    total++;
    if (hexb !== {7'b1000000, 7'b0001110}) begin
      bad++;
      $display("FAIL live_0F: got %h want %h", hexb, {7'b1000000, 7'b0001110});
    end
    for (int n = 0; n < 16; n++) begin
      d = {4'(n), 4'(15 - n)}; #1;
      total++;
      if (hexb !== {glyph[n], glyph[15 - n]}) begin
        bad++;
        $display("FAIL live_nib%0d: got %h want %h", n, hexb, {glyph[n], glyph[15 - n]});
      end
    end
  endtask

  initial begin
    glyph = '{G0, G1, G2, G3, G4, G5, G6, G7, G8, G9, GA, GB, GC, GD, GE, GF};
    d = 8'h00; cap_en = 1'b0; clr = 1'b0; mode = 1'b0; view_sel = 2'd0;
    d3 = 8'h00; cap3 = 1'b0; view3 = 2'd0;
    test_reset();
    test_ring();
    test_halt();
    test_clr_priority();
    test_depth3();
    test_live();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_hex_capture_bank
`default_nettype wire
